// File: rtl/dw_arith_pkg.sv
// Shared definitions for the chunk-serial arithmetic blocks.
package dw_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add_seq_state_t;

  // Number of slices needed to cover a width-bit operand.
  function automatic int nchunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // True when the slice size evenly divides the operand width.
  function automatic bit chunk_fits(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/dw_chunk_adder.sv
// One chunk-wide slice adder; the only arithmetic in the sequential adder.
module dw_chunk_adder #(
  parameter int chunk = 6
) (
  input  logic [chunk-1:0] a,
  input  logic [chunk-1:0] b,
  input  logic             ci,
  output logic [chunk-1:0] s,
  output logic             co
);

  // (chunk+1)-bit sum so the slice carry-out falls out as the top bit.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{chunk{1'b0}}, ci};
  end

endmodule

// File: rtl/dw01_add_seq.sv
// Chunk-serial adder: {CO, SUM} = A + B + CI, one slice per clock, LSB first.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | adding slice cnt each cycle, carry rippling between slices
// DONE  | result held on SUM/CO with out_valid high until out_ready
module dw01_add_seq
  import dw_arith_pkg::*;
#(
  parameter int width = 18,
  parameter int chunk = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             CI,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] SUM,
  output logic             CO,
  output logic             busy
);

  localparam int NCH = nchunks(width, chunk);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if (!chunk_fits(width, chunk)) begin : g_bad_chunk
    $error("dw01_add_seq: width must be a non-zero multiple of chunk");
  end

  add_seq_state_t state_q, state_d;

  // Operands and result are stored slice-wise so the slice mux is a plain index.
  logic [NCH-1:0][chunk-1:0] a_q, b_q, sum_q;
  logic                      carry_q;
  logic                      co_q;
  logic [CW-1:0]             cnt_q;

  logic                      accept;
  logic                      last_slice;
  logic [chunk-1:0]          slice_s;
  logic                      slice_c;

  dw_chunk_adder #(.chunk(chunk)) u_slice (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; handshake outputs depend on the registered state only.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_slice = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          last_slice = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture at acceptance, then one slice written per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      carry_q <= CI;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[cnt_q] <= slice_s;
      carry_q      <= slice_c;
      if (last_slice) begin
        co_q  <= slice_c;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign SUM = sum_q;
  assign CO  = co_q;

endmodule

// File: tb/tb_dw01_add_seq.sv
// Self-checking bench: directed corner cases plus randomized streaming
// against a plain A+B+CI reference, on chunk=6, chunk=1 and chunk=width builds.
`timescale 1ns/1ps
module tb_dw01_add_seq;

  localparam int W = 18;

  logic          clk;
  logic          rst;
  logic [W-1:0]  A, B;
  logic          CI;
  logic          in_valid_v  [3];
  logic          in_ready_v  [3];
  logic          out_valid_v [3];
  logic          out_ready_v [3];
  logic [W-1:0]  sum_v       [3];
  logic          co_v        [3];
  logic          busy_v      [3];

  int n_vec;
  int n_err;

  dw01_add_seq #(.width(W), .chunk(6)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .A(A), .B(B), .CI(CI), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .SUM(sum_v[0]), .CO(co_v[0]), .busy(busy_v[0])
  );

  dw01_add_seq #(.width(W), .chunk(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .A(A), .B(B), .CI(CI), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .SUM(sum_v[1]), .CO(co_v[1]), .busy(busy_v[1])
  );

  dw01_add_seq #(.width(W), .chunk(W)) u_cw (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .A(A), .B(B), .CI(CI), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .SUM(sum_v[2]), .CO(co_v[2]), .busy(busy_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // Full transaction on the chunk=6 instance with latency and result checks.
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic ci);
    logic [W:0] want;
    int n;
    want = ref_add(a, b, ci);
    A = a; B = b; CI = ci;
    in_valid_v[0] = 1'b1;
    n = 0;
    while (!in_ready_v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(in_ready_v[0]), 32'd1);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    A = W'($urandom); B = W'($urandom); CI = 1'($urandom);
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_sum"}, 32'(sum_v[0]), 32'(want[W-1:0]));
    chk({tag, "_co"}, 32'(co_v[0]), 32'(want[W]));
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    chk({tag, "_release"}, 32'({out_valid_v[0], in_ready_v[0]}), 32'b01);
  endtask

  // Back-to-back traffic with in_valid and out_ready held high on instance idx.
  task automatic stream(input int idx, input int nch, input int count);
    logic [W:0] exp_q[$];
    logic [W:0] want;
    int cyc, last_acc, done;
    cyc = 0; last_acc = -1; done = 0;
    in_valid_v[idx]  = 1'b1;
    out_ready_v[idx] = 1'b1;
    while (done < count && cyc < 25 * count + 100) begin
      case ($urandom_range(0, 5))
        0:       begin A = '1; B = W'($urandom); end
        1:       begin A = W'($urandom); B = '1; end
        default: begin A = W'($urandom); B = W'($urandom); end
      endcase
      CI = 1'($urandom);
      if (in_ready_v[idx]) begin
        exp_q.push_back(ref_add(A, B, CI));
        if (last_acc >= 0) chk($sformatf("spacing%0d", idx), 32'(cyc - last_acc), 32'(nch + 2));
        last_acc = cyc;
      end
      if (out_valid_v[idx]) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("stray_result%0d", idx), 32'd1, 32'd0);
        end else begin
          want = exp_q.pop_front();
          chk($sformatf("stream%0d", idx), 32'({co_v[idx], sum_v[idx]}), 32'(want));
          done++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("stream%0d_count", idx), 32'(done), 32'(count));
    in_valid_v[idx]  = 1'b0;
    out_ready_v[idx] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [W:0] want;
    int n;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b1;
      out_ready_v[i] = 1'b0;
    end
    rst = 1'b1;
    A = W'($urandom); B = W'($urandom); CI = 1'($urandom);

    // Reset with in_valid held high and random operands.
    repeat (3) begin
      @(negedge clk);
      A = W'($urandom); B = W'($urandom); CI = 1'($urandom);
    end
    chk("rst_sum", 32'(sum_v[0]), 32'd0);
    chk("rst_co", 32'(co_v[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_in_ready", 32'(in_ready_v[0]), 32'd1);
    for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", 32'(busy_v[0]), 32'd0);

    // Directed arithmetic corners.
    op("ripple", 18'h3FFFF, 18'h00001, 1'b0);
    op("carry_in", 18'h12345, 18'h0ABCD, 1'b1);
    op("all_ones", 18'h3FFFF, 18'h3FFFF, 1'b1);

    // Backpressure: result held while out_ready low, new request refused.
    A = 18'h2AAAA; B = 18'h15556; CI = 1'b1;
    want = ref_add(A, B, CI);
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_latency", 32'(n), 32'd3);
    A = 18'h00F0F; B = 18'h30303; CI = 1'b0;
    in_valid_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", 32'({out_valid_v[0], co_v[0], sum_v[0]}), 32'({1'b1, want}));
      chk("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    chk("bp_idle_after_handshake", 32'({in_ready_v[0], busy_v[0]}), 32'b10);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    chk("bp_next_accepted", 32'(busy_v[0]), 32'd1);
    want = ref_add(18'h00F0F, 18'h30303, 1'b0);
    A = '0; B = '0;
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_next_result", 32'({co_v[0], sum_v[0]}), 32'(want));
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;

    // Reset after the first slice of a rippling add.
    A = 18'h3FFFF; B = 18'h00001; CI = 1'b0;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs",
        32'({sum_v[0], co_v[0], out_valid_v[0], busy_v[0], in_ready_v[0]}), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 32'({busy_v[0], in_ready_v[0]}), 32'b01);
    op("after_rst", 18'h00001, 18'h00002, 1'b0);

    // Streaming on the default, chunk=1 and chunk=width builds.
    stream(0, 3, 1000);
    stream(1, 18, 150);
    stream(2, 1, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
